rot_sequencer: RTL and testbench
================================

Name: rot_sequencer

Overview:
- Control stage that sits directly upstream of the 4-bit barrel rotator (rotate-right by {S1,S0}).
- Accepts words over a valid/ready handshake and drives the rotator's W, S0 and S1 inputs.
- Captures the rotator's Y output and returns results through a small output FIFO with its own valid/ready handshake.
- Supports two modes:
  - single: one rotator pass by the full amount.
  - step: amt passes of rotate-by-1, fed back through a work register.

Parameters:
FIFO_DEPTH, 2, output FIFO entries; power of two, >= 2.
CNT_W, $clog2(FIFO_DEPTH)+1, FIFO occupancy counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input word present.
in_ready  output  1  block can accept (state IDLE).
in_data  input  4  word to rotate.
in_amt  input  2  rotate-right amount 0..3.
in_step  input  1  1 = step mode, 0 = single mode.
shift_w  output  4  to rotator W.
shift_s0  output  1  to rotator S0.
shift_s1  output  1  to rotator S1.
shift_y  input  4  from rotator Y (combinational return path).
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head.
out_data  output  4  FIFO head.

Behaviour:
- Reset (async assert, sync release): state=IDLE, work=0, cnt=0, mode=0, FIFO empty.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=0, shift_w=0, shift_s0/s1=0.
  - Reset mid-operation discards the in-flight word and all FIFO contents.
- States are IDLE, ROTATE and PUSH.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: work<=in_data, cnt<=in_amt, mode<=in_step.
  - Next state: PUSH if in_amt==0, otherwise ROTATE.
- ROTATE:
  - shift_w=work.
  - Single mode: {s1,s0}=cnt; work<=shift_y; go to PUSH after 1 cycle.
  - Step mode: {s1,s0}=2'b01; work<=shift_y; cnt<=cnt-1; go to PUSH when cnt==1.
- PUSH:
  - If FIFO not full: write work, go to IDLE.
  - If FIFO full: hold in PUSH with work unchanged.
  - Fullness is evaluated on the registered count only, so a same-cycle pop does not enable the push.
- Outside ROTATE, shift_s0 and shift_s1 are 0. shift_w=work in all states.
- Latency from the accept edge (cycle 0), FIFO empty, out_ready=1:
  - amt=0: out_valid in cycle 2.
  - Single mode: out_valid in cycle 3.
  - Step mode with amt=k: out_valid in cycle k+2.
- FIFO:
  - out_valid=(count!=0); out_data=head, which is 0 when empty.
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- in_valid while not IDLE is ignored; the source must hold the word.
- in_step is ignored when in_amt==0.

Optional Feature:
- Macro: ROT_SEQ_STATS_EN.
- When defined:
  - Adds output port op_count [7:0]: number of FIFO pushes, saturating at 255, reset to 0.
  - Adds output port stall_flag [0:0]: sticky, set on any cycle spent in PUSH with the FIFO full, cleared only by reset.
- When undefined: neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Package rot_seq_pkg holds:
  - state enum (IDLE=2'd0, ROTATE=2'd1, PUSH=2'd2);
  - MODE_SINGLE=1'b0, MODE_STEP=1'b1;
  - DATA_W=4, AMT_W=2.
- Sub-module rot_out_fifo is parameterised by FIFO_DEPTH and DATA_W. It has push/pop/full/empty signals and head data.
- The FSM, work register and step counter stay in rot_sequencer.
- The bench instantiates the existing 4-bit rotator and wires its ports to shift_*.

Test Plan:
- Single mode, in_data=4'b1011, amt=1, out_ready=1 -> out_data=4'b1101, out_valid first asserted in cycle 3. With amt=2 -> 4'b1110.
- Step mode, in_data=4'b1000, amt=3 -> shift_s0/s1 read 2'b01 for exactly 3 cycles; work sequence 0100, 0010, 0001; out_data=4'b0001 in cycle 5.
- amt=0 with in_step=1, in_data=4'b0110 -> no ROTATE cycle, shift_s stays 0, out_data=4'b0110 in cycle 2.
- out_ready=0, FIFO_DEPTH=2, three single-mode words (0001 amt1, 0010 amt1, 0100 amt1):
  - FIFO fills with 1000 and 0001; third word holds in PUSH and in_ready=0.
  - Raise out_ready: outputs drain in order 1000, 0001, 0010, with no loss or duplication.
- Assert rst_n=0 during cycle 2 of a step-mode amt=3 operation -> immediately out_valid=0, shift_s=0, in_ready=1. A new word after release completes normally.
- With ROT_SEQ_STATS_EN defined: 300 back-to-back ops -> op_count=255. The full-FIFO scenario above sets stall_flag=1, which persists until reset.

Source files
------------

// File: rtl/rot_seq_pkg.sv
// Shared types and widths for the rotator sequencer.
package rot_seq_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned AMT_W  = 2;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_STEP   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    PUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/rot_out_fifo.sv
// Result FIFO for the rotator sequencer; head reads as zero when empty.
module rot_out_fifo #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned DATA_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rot_sequencer.sv
// Drives a 4-bit rotate-right unit in single or step mode and queues results.
// Optional statistics ports (op_count, stall_flag) under ROT_SEQ_STATS_EN.
module rot_sequencer
  import rot_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_step,
  output logic [DATA_W-1:0] shift_w,
  output logic              shift_s0,
  output logic              shift_s1,
  input  logic [DATA_W-1:0] shift_y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef ROT_SEQ_STATS_EN
  ,
  output logic [7:0]        op_count,
  output logic [0:0]        stall_flag
`endif
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_work;
  logic [DATA_W-1:0] w_work_nxt;
  logic [AMT_W-1:0]  r_cnt;
  logic [AMT_W-1:0]  w_cnt_nxt;
  logic              r_mode;
  logic              w_mode_nxt;
  logic [AMT_W-1:0]  w_s;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_SINGLE;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_s         = '0;
    w_push      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_work_nxt  = in_data;
          w_cnt_nxt   = in_amt;
          w_mode_nxt  = in_step;
          w_state_nxt = (in_amt == '0) ? PUSH : ROTATE;
        end
      end
      ROTATE: begin
        w_work_nxt = shift_y;
        if (r_mode == MODE_STEP) begin
          w_s       = AMT_W'(1);
          w_cnt_nxt = r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) w_state_nxt = PUSH;
        end else begin
          w_s         = r_cnt;
          w_state_nxt = PUSH;
        end
      end
      PUSH: begin
        // Registered fullness only: a same-cycle pop does not free a slot.
        if (!w_full) begin
          w_push      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign in_ready             = (r_state == IDLE);
  assign shift_w              = r_work;
  assign {shift_s1, shift_s0} = w_s;
  assign out_valid            = !w_empty;
  assign w_pop                = out_valid && out_ready;

  rot_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_work),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (out_data)
  );

`ifdef ROT_SEQ_STATS_EN
  logic [7:0] r_op_count;
  logic       r_stall;

  // Saturating push counter and sticky full-FIFO stall indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
      r_stall    <= 1'b0;
    end else begin
      if (w_push && (r_op_count != 8'hFF)) r_op_count <= r_op_count + 8'd1;
      if ((r_state == PUSH) && w_full) r_stall <= 1'b1;
    end
  end

  assign op_count   = r_op_count;
  assign stall_flag = r_stall;
`endif

endmodule

// File: tb/tb_rot_sequencer.sv
// Self-checking bench for rot_sequencer with a behavioural 4-bit rotator.
module tb_rot_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_step;
  logic [3:0] in_data;
  logic [1:0] in_amt;
  logic [3:0] shift_w, shift_y;
  logic       shift_s0, shift_s1;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
`ifdef ROT_SEQ_STATS_EN
  logic [7:0] op_count;
  logic [0:0] stall_flag;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  rot_sequencer #(.FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_step   (in_step),
    .shift_w   (shift_w),
    .shift_s0  (shift_s0),
    .shift_s1  (shift_s1),
    .shift_y   (shift_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef ROT_SEQ_STATS_EN
    ,
    .op_count  (op_count),
    .stall_flag(stall_flag)
`endif
  );

  // Barrel rotator: rotate right by {S1,S0}.
  function automatic logic [3:0] rotator(input logic [3:0] w, input logic [1:0] s);
    logic [7:0] t;
    t = {w, w} >> s;
    return t[3:0];
  endfunction
  assign shift_y = rotator(shift_w, {shift_s1, shift_s0});

  // Reference: final result is the word rotated right by amt, in either mode.
  function automatic logic [3:0] rotr(input logic [3:0] d, input logic [1:0] a);
    logic [3:0] y;
    for (int i = 0; i < 4; i++) y[i] = d[(i + int'(a)) % 4];
    return y;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [1:0] s_hist [32];
  logic [3:0] w_hist [32];

  // Called at mid cycle 1; returns the cycle in which out_valid first shows.
  task automatic wait_valid(output int cyc, output int rot_cycles);
    cyc = 1;
    rot_cycles = 0;
    while (!out_valid && cyc < 30) begin
      s_hist[cyc] = {shift_s1, shift_s0};
      w_hist[cyc] = shift_w;
      if ({shift_s1, shift_s0} != 2'b00) rot_cycles++;
      @(negedge clk);
      cyc++;
    end
  endtask

  // Called at a negedge; returns at mid cycle 1 after the accept edge.
  task automatic send(input logic [3:0] d, input logic [1:0] a, input logic st, output logic ok);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_step  = st;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [3:0] exp_q [$];
  logic [3:0] got_q [$];
  logic       ok, acc;
  int         cyc, rots, accepts;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_amt = '0; in_step = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 8'(in_ready), 8'd1);
    check("rst_out_valid", 8'(out_valid), 8'd0);
    check("rst_out_data", 8'(out_data), 8'd0);
    check("rst_shift_w", 8'(shift_w), 8'd0);
    check("rst_shift_s", 8'({shift_s1, shift_s0}), 8'd0);
`ifdef ROT_SEQ_STATS_EN
    check("rst_op_count", op_count, 8'd0);
    check("rst_stall", 8'(stall_flag), 8'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Single mode, amt 1 and 2
    send(4'b1011, 2'd1, 1'b0, ok);
    wait_valid(cyc, rots);
    check("single1_lat", 8'(cyc), 8'd3);
    check("single1_data", 8'(out_data), 8'b1101);
    @(negedge clk);
    send(4'b1011, 2'd2, 1'b0, ok);
    wait_valid(cyc, rots);
    check("single2_lat", 8'(cyc), 8'd3);
    check("single2_data", 8'(out_data), 8'b1110);
    @(negedge clk);

    // Step mode, amt 3
    send(4'b1000, 2'd3, 1'b1, ok);
    wait_valid(cyc, rots);
    check("step_lat", 8'(cyc), 8'd5);
    check("step_rot_cycles", 8'(rots), 8'd3);
    for (int i = 1; i <= 3; i++) check("step_s", 8'(s_hist[i]), 8'd1);
    check("step_work1", 8'(w_hist[2]), 8'b0100);
    check("step_work2", 8'(w_hist[3]), 8'b0010);
    check("step_work3", 8'(w_hist[4]), 8'b0001);
    check("step_data", 8'(out_data), 8'b0001);
    @(negedge clk);

    // amt 0 with step requested
    send(4'b0110, 2'd0, 1'b1, ok);
    wait_valid(cyc, rots);
    check("amt0_lat", 8'(cyc), 8'd2);
    check("amt0_rot_cycles", 8'(rots), 8'd0);
    check("amt0_data", 8'(out_data), 8'b0110);
    @(negedge clk);
    check("amt0_popped", 8'(out_valid), 8'd0);
`ifdef ROT_SEQ_STATS_EN
    check("op_count_4", op_count, 8'd4);
    check("stall_clear", 8'(stall_flag), 8'd0);
`endif

    // Full FIFO backpressure
    out_ready = 1'b0;
    send(4'b0001, 2'd1, 1'b0, ok);
    check("full_send1", 8'(ok), 8'd1);
    send(4'b0010, 2'd1, 1'b0, ok);
    check("full_send2", 8'(ok), 8'd1);
    send(4'b0100, 2'd1, 1'b0, ok);
    check("full_send3", 8'(ok), 8'd1);
    repeat (4) @(negedge clk);
    check("full_in_ready", 8'(in_ready), 8'd0);
    check("full_out_valid", 8'(out_valid), 8'd1);
    check("full_head", 8'(out_data), 8'b1000);
`ifdef ROT_SEQ_STATS_EN
    check("full_stall", 8'(stall_flag), 8'd1);
`endif
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 20; i++) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      @(negedge clk);
    end
    check("drain_count", 8'(got_q.size()), 8'd3);
    check("drain_0", 8'(got_q[0]), 8'b1000);
    check("drain_1", 8'(got_q[1]), 8'b0001);
    check("drain_2", 8'(got_q[2]), 8'b0010);
    check("drain_empty", 8'(out_valid), 8'd0);
    check("drain_in_ready", 8'(in_ready), 8'd1);
`ifdef ROT_SEQ_STATS_EN
    check("stall_sticky", 8'(stall_flag), 8'd1);
`endif

    // Reset during a step-mode operation with a word held in the FIFO
    out_ready = 1'b0;
    send(4'b0101, 2'd0, 1'b0, ok);
    send(4'b1000, 2'd3, 1'b1, ok);
    @(negedge clk);
    check("pre_rst_shift_s", 8'({shift_s1, shift_s0}), 8'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 8'(out_valid), 8'd0);
    check("mid_rst_shift_s", 8'({shift_s1, shift_s0}), 8'd0);
    check("mid_rst_in_ready", 8'(in_ready), 8'd1);
    check("mid_rst_out_data", 8'(out_data), 8'd0);
`ifdef ROT_SEQ_STATS_EN
    check("mid_rst_stall", 8'(stall_flag), 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(4'b1011, 2'd2, 1'b0, ok);
    wait_valid(cyc, rots);
    check("post_rst_lat", 8'(cyc), 8'd3);
    check("post_rst_data", 8'(out_data), 8'b1110);
    @(negedge clk);
    check("post_rst_empty", 8'(out_valid), 8'd0);

    // Random traffic against an in-order scoreboard
    exp_q.delete();
    acc = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 4'($urandom);
        in_amt   = 2'($urandom);
        in_step  = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("rand_spurious", 8'(out_valid), 8'd0);
        else check("rand_data", 8'(out_data), 8'(exp_q.pop_front()));
      end
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(rotr(in_data, in_amt));
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("rand_spurious", 8'(out_valid), 8'd0);
        else check("rand_drain_data", 8'(out_data), 8'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
    check("rand_all_seen", 8'(exp_q.size()), 8'd0);
    check("rand_final_empty", 8'(out_valid), 8'd0);

`ifdef ROT_SEQ_STATS_EN
    // 300 back-to-back operations saturate the push counter
    accepts = 0;
    out_ready = 1'b1;
    in_amt = 2'd0;
    in_step = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 2000 && accepts < 300; c++) begin
      in_data = 4'($urandom);
      if (in_ready) accepts++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("stats_accepts", 8'(accepts / 2), 8'd150);
    check("stats_op_count", op_count, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
